// File: rtl/shift_sequencer_pkg.sv
// Shared mode-pin encodings and FSM state type for the shift register sequencer.
package shift_sequencer_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sequencer_bit_counter.sv
// Counts shift edges within a frame; flags the edge that moves the last bit out.
module shift_bit_counter #(
    parameter int LENGTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(LENGTH + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CW'(LENGTH - 1));

endmodule

// File: rtl/shift_sequencer.sv
// Drives a universal shift register as a framed parallel-to-serial transmitter:
// load a word, shift it out LENGTH times, report the exiting bit and a DONE pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int LENGTH = 4
) (
    input  logic              CLOCK,
    input  logic              _MR,
    input  logic              START,
    input  logic [LENGTH-1:0] DATA,
    input  logic              DIR,
    input  logic              FILL,
    input  logic              HOLD,
    input  logic [LENGTH-1:0] Q_FB,
    output logic              READY,
    output logic              S1,
    output logic              S0,
    output logic [LENGTH-1:0] P_OUT,
    output logic              DSR,
    output logic              DSL,
    output logic              SOUT,
    output logic              SOUT_VALID,
    output logic              DONE
);

    state_t            state_q, state_d;
    logic [LENGTH-1:0] data_q, data_d;
    logic              dir_q, dir_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_last;
    logic [1:0]        mode;

    shift_bit_counter #(
        .LENGTH (LENGTH)
    ) u_bit_counter (
        .clk   (CLOCK),
        .rst_n (_MR),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    data_d  = DATA;
                    dir_d   = DIR;
                    cnt_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (!HOLD) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge _MR) begin
        if (!_MR) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
        end
    end

    // HOLD is the only input allowed to reach the outputs combinationally.
    always_comb begin
        mode       = MODE_HOLD;
        READY      = 1'b0;
        P_OUT      = '0;
        SOUT       = 1'b0;
        SOUT_VALID = 1'b0;
        DONE       = 1'b0;
        case (state_q)
            ST_IDLE: READY = 1'b1;
            ST_LOAD: begin
                mode  = MODE_LOAD;
                P_OUT = data_q;
            end
            ST_SHIFT: begin
                SOUT = dir_q ? Q_FB[0] : Q_FB[LENGTH-1];
                if (!HOLD) begin
                    mode       = dir_q ? MODE_SHR : MODE_SHL;
                    SOUT_VALID = 1'b1;
                end
            end
            ST_DONE: DONE = 1'b1;
            default: mode = MODE_HOLD;
        endcase
    end

    assign S1  = mode[1];
    assign S0  = mode[0];
    assign DSR = FILL;
    assign DSL = FILL;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: shift_sequencer paired with a 4-bit universal shift register model.
module tb_shift_sequencer;

    localparam int LENGTH = 4;

    logic       clk = 1'b0;
    logic       mr_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] data = 4'h0;
    logic       dir = 1'b0;
    logic       fill = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] q;
    logic       ready, s1, s0, dsr, dsl, sout, sout_valid, done;
    logic [3:0] p_out;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.LENGTH(LENGTH)) dut (
        .CLOCK      (clk),
        ._MR        (mr_n),
        .START      (start),
        .DATA       (data),
        .DIR        (dir),
        .FILL       (fill),
        .HOLD       (hold),
        .Q_FB       (q),
        .READY      (ready),
        .S1         (s1),
        .S0         (s0),
        .P_OUT      (p_out),
        .DSR        (dsr),
        .DSL        (dsl),
        .SOUT       (sout),
        .SOUT_VALID (sout_valid),
        .DONE       (done)
    );

    always #5 clk = ~clk;

    // Universal shift register: 01 toward MSB (DSR enters Q[0]), 10 toward LSB (DSL enters Q[3]).
    always @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            q <= 4'h0;
        end else begin
            case ({s1, s0})
                2'b01:   q <= {q[2:0], dsr};
                2'b10:   q <= {dsl, q[3:1]};
                2'b11:   q <= p_out;
                default: q <= q;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic       fill;
        int         hold_start;
        int         hold_len;
        bit         hold_in_shift;
        int         extra;
        bit         busy;
        logic [3:0] exp_bits;   // first bit out in [3]
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    task automatic run_frame(input vec_t v, input int idx);
        int         done_cyc = -1;
        int         ready_cyc = -1;
        int         nbits = 0;
        logic [3:0] got = 4'h0;
        logic [3:0] prev_q = 4'h0;
        bit         prev_held = 1'b0;
        bit         held;
        @(negedge clk);
        chk("idle_ready", ready, 1);
        data  = v.data;
        dir   = v.dir;
        fill  = v.fill;
        start = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            data  = v.busy ? 4'hF : ~v.data;
            dir   = ~v.dir;
            start = v.busy && (cyc == 2 || cyc == 3);
            held  = (cyc >= v.hold_start) && (cyc < v.hold_start + v.hold_len);
            hold  = held;
            @(negedge clk);
            if (cyc == 0) begin
                chk("load_mode", {s1, s0}, 2'b11);
                chk("load_pout", p_out, v.data);
                chk("load_ready", ready, 0);
            end else begin
                chk("no_load_mode", ({s1, s0} == 2'b11), 0);
            end
            if (cyc == 1) begin
                chk("dsr_fill", dsr, v.fill);
                chk("dsl_fill", dsl, v.fill);
            end
            if (prev_held && v.hold_in_shift) chk("hold_q_frozen", q, prev_q);
            if (held && v.hold_in_shift) begin
                chk("hold_valid", sout_valid, 0);
                chk("hold_mode", {s1, s0}, 2'b00);
            end
            if (sout_valid) begin
                got = {got[2:0], sout};
                nbits++;
                chk("shift_mode", {s1, s0}, v.dir ? 2'b10 : 2'b01);
            end
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                chk("final_q", q, v.exp_q);
            end
            prev_q    = q;
            prev_held = held;
            if (ready) begin
                ready_cyc = cyc;
                break;
            end
        end
        hold  = 1'b0;
        start = 1'b0;
        chk("bit_count", nbits, 4);
        chk("bits", got, v.exp_bits);
        chk("done_cycle", done_cyc, 5 + v.extra);
        chk("ready_cycle", ready_cyc, 6 + v.extra);
        $display("frame %0d: data=%b dir=%b fill=%b bits=%b done@%0d ready@%0d",
                 idx, v.data, v.dir, v.fill, got, done_cyc, ready_cyc);
    endtask

    initial begin
        int         nloads;
        int         load_cyc[8];
        logic [15:0] cbits;
        int         ncbits;

        vecs[0] = '{4'b1011, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 4'b1011, 4'b0000};
        vecs[1] = '{4'b1011, 1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 4'b1101, 4'b1111};
        vecs[2] = '{4'b0110, 1'b0, 1'b0, 2, 2, 1'b1, 2, 1'b0, 4'b0110, 4'b0000};
        vecs[3] = '{4'b1011, 1'b0, 1'b1, 0, 0, 1'b0, 0, 1'b1, 4'b1011, 4'b1111};
        vecs[4] = '{4'b0110, 1'b1, 1'b0, 0, 1, 1'b0, 0, 1'b0, 4'b0110, 4'b0000};
        vecs[5] = '{4'b1001, 1'b0, 1'b1, 4, 1, 1'b1, 1, 1'b0, 4'b1001, 4'b1111};
        vecs[6] = '{4'b1100, 1'b1, 1'b1, 5, 2, 1'b0, 0, 1'b0, 4'b0011, 4'b1111};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_mode", {s1, s0}, 2'b00);
        chk("rst_pout", p_out, 0);
        chk("rst_sout", sout, 0);
        chk("rst_valid", sout_valid, 0);
        chk("rst_done", done, 0);
        mr_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], i);
        end

        // Reset mid-SHIFT abandons the frame immediately.
        @(negedge clk);
        data  = 4'b1011;
        dir   = 1'b0;
        fill  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 mr_n = 1'b0;
        #1;
        chk("mr_mode", {s1, s0}, 2'b00);
        chk("mr_ready", ready, 1);
        chk("mr_valid", sout_valid, 0);
        chk("mr_q", q, 0);
        chk("mr_done", done, 0);
        @(negedge clk);
        mr_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("mr_no_done", done, 0);
            chk("mr_idle_mode", {s1, s0}, 2'b00);
        end
        $display("reset mid-frame: q=%b ready=%b", q, ready);

        // START held high: back-to-back frames every 7 cycles.
        nloads = 0;
        ncbits = 0;
        cbits  = 16'h0;
        data   = 4'b1001;
        dir    = 1'b0;
        fill   = 1'b0;
        start  = 1'b1;
        for (int cyc = 0; cyc < 28; cyc++) begin
            @(posedge clk);
            #1 start = (cyc < 27);
            @(negedge clk);
            if ({s1, s0} == 2'b11 && nloads < 8) begin
                load_cyc[nloads] = cyc;
                nloads++;
            end
            if (sout_valid && ncbits < 16) begin
                cbits = {cbits[14:0], sout};
                ncbits++;
            end
        end
        start = 1'b0;
        chk("cont_loads", nloads, 4);
        for (int k = 1; k < 4; k++) begin
            if (k < nloads) chk("cont_period", load_cyc[k] - load_cyc[k-1], 7);
        end
        chk("cont_nbits", ncbits, 16);
        chk("cont_bits", cbits, 16'b1001_1001_1001_1001);
        $display("continuous: loads=%0d bits=%b", nloads, cbits);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Upstream controller for the team's 4-bit universal bidirectional shift register (mode pins S1/S0, serial inputs DSR/DSL, parallel input P, output Q).
- Accepts a parallel word over a valid/ready handshake and drives the register's mode pins to load the word, then shift it out LENGTH times in the requested direction.
- Reads the register's Q back and presents the outgoing serial bit with a valid strobe.
- Sits between a word source and the shift register, turning the register into a framed parallel-to-serial transmitter.

Parameters:
- LENGTH, 4, register width in bits; must be 2 or more. The counter is $clog2(LENGTH+1) bits wide.

Ports:
- CLOCK  input  1  rising-edge clock; the same clock as the shift register.
- _MR  input  1  asynchronous, active-low master reset; also shared with the shift register.
- START  input  1  request to transmit DATA. Sampled only when READY=1.
- DATA  input  LENGTH  word to transmit.
- DIR  input  1  0 = shift toward MSB, so bits exit from Q[LENGTH-1]. 1 = shift toward LSB, so bits exit from Q[0].
- FILL  input  1  bit shifted into the vacated end; drives both DSR and DSL.
- HOLD  input  1  pause request, effective only in SHIFT.
- Q_FB  input  LENGTH  the register's Q outputs.
- READY  output  1  high in IDLE; the block can accept START.
- S1, S0  output  1 each  register mode: 00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load.
- P_OUT  output  LENGTH  parallel-load word, connected to the register's P input.
- DSR, DSL  output  1 each  both equal FILL.
- SOUT  output  1  outgoing serial bit.
- SOUT_VALID  output  1  high in each SHIFT cycle in which a bit leaves the register.
- DONE  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (_MR=0, takes effect immediately and asynchronously):
  - state goes to IDLE; data_reg, dir_reg and cnt are cleared to 0.
  - Outputs: READY=1, S1S0=00, P_OUT=0, SOUT=0, SOUT_VALID=0, DONE=0.
  - Reset in the middle of a frame abandons the frame. There is no DONE pulse and no residual shifting.
- FSM is Moore-style; all outputs decode from state and registers only, with no combinational path from START or HOLD except as noted in SHIFT.
- IDLE:
  - S1S0=00, READY=1.
  - On a rising edge with START=1: data_reg<=DATA, dir_reg<=DIR, cnt<=0, state goes to LOAD.
- LOAD (exactly 1 cycle):
  - S1S0=11, P_OUT=data_reg, READY=0.
  - The register captures the word at the next edge; state then goes to SHIFT.
- SHIFT:
  - S1S0 = 01 if dir_reg=0, 10 if dir_reg=1.
  - SOUT = Q_FB[LENGTH-1] if dir_reg=0, Q_FB[0] if dir_reg=1. This is the bit at the exit end before the edge.
  - SOUT_VALID=1.
  - If HOLD=1: S1S0=00, SOUT_VALID=0, cnt frozen, state unchanged. HOLD is the only combinational input-to-output path.
  - Otherwise cnt increments each edge. The edge where cnt=LENGTH-1 goes to DONE.
- DONE (exactly 1 cycle): S1S0=00, DONE=1, READY=0; next state is IDLE.
- Latency with no HOLD:
  - START is sampled at edge 0; LOAD occupies cycle 0.
  - SHIFT occupies cycles 1..LENGTH; DONE is in cycle LENGTH+1.
  - READY returns in cycle LENGTH+2.
  - Each HOLD cycle adds one cycle.
- Boundary conditions:
  - START while READY=0 is ignored and not queued.
  - START held high continuously produces back-to-back frames separated only by the DONE and IDLE cycles.
  - DATA and DIR changing after acceptance have no effect on the frame.
  - FILL may change at any time; the register samples it at each shift edge.
  - HOLD asserted in LOAD, DONE or IDLE is ignored.
  - HOLD asserted for the final bit delays DONE until HOLD is released.
  - S1S0 is never 11 outside LOAD.

Decomposition:
- Shared package / header holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11;
  - state encodings IDLE, LOAD, SHIFT, DONE.
- One natural sub-module: shift_bit_counter, a LENGTH-aware counter with clear, enable and terminal-count outputs.
- FSM and output decode stay in the top level.

Test Plan:
- The bench pairs the block with the team's 4-bit universal shift register model; LENGTH=4.
- Reset: _MR low mid-SHIFT -> immediately S1S0=00, READY=1, SOUT_VALID=0; register Q=0000; no DONE pulse.
- Left frame: DATA=1011, DIR=0, FILL=0, START for 1 cycle ->
  - S1S0=11 for one cycle;
  - SOUT = 1,0,1,1 on four SOUT_VALID cycles;
  - DONE in cycle 5; READY in cycle 6; Q=0000.
- Right frame: DATA=1011, DIR=1, FILL=1 -> SOUT = 1,1,0,1; final Q=1111; DONE after 4 valid bits.
- HOLD: DATA=0110, DIR=0, HOLD high for 2 cycles after the first bit ->
  - SOUT_VALID low and Q unchanged for those 2 cycles;
  - full bit sequence 0,1,1,0; DONE delayed by exactly 2 cycles.
- Busy START: START pulses during SHIFT with DATA=1111 -> ignored; the current frame bits are unaltered.
- Continuous START with DATA=1001 -> frames repeat with a period of 7 cycles; each frame outputs 1,0,0,1.
